// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch front end.
package fetch_pkg;

  localparam int INSTR_BYTES = 4;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 32;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] instruction;
    logic [DEF_ADDR_W-1:0] pc_plus4;
  } fetch_entry_t;

  // Bits needed to count 0..depth inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer between instruction memory and decode.
// Flush wins over push and pop; pointers wrap naturally since DEPTH is a power of two.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter type entry_t = fetch_entry_t,
  parameter int  DEPTH   = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        push,
  input  logic                        pop,
  input  logic                        flush,
  input  entry_t                      push_entry,
  output entry_t                      head,
  output logic [occ_width(DEPTH)-1:0] count,
  output logic                        full,
  output logic                        empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = occ_width(DEPTH);

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == OCC_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count_d = count_q + OCC_W'(1);
      end else if (do_pop && !do_push) begin
        count_d = count_q - OCC_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC sequencer, wait-state tolerant memory request
// and a prefetch queue feeding decode through a valid/ready handshake.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                        clock,
  input  logic                        reset,
  output logic                        imem_req,
  output logic [ADDR_W-1:0]           imem_addr,
  input  logic                        imem_ready,
  input  logic [DATA_W-1:0]           imem_data,
  input  logic                        redirect,
  input  logic [ADDR_W-1:0]           redirect_pc,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_instruction,
  output logic [ADDR_W-1:0]           out_pc_plus4,
  output logic [occ_width(DEPTH)-1:0] occupancy
);

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(INSTR_BYTES);

  typedef struct packed {
    logic [DATA_W-1:0] instruction;
    logic [ADDR_W-1:0] pc_plus4;
  } entry_t;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_next;
  logic              fetch_accept;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [1:0]        redirect_pc_unused;
  entry_t            push_entry;
  entry_t            head;

  assign redirect_pc_unused = redirect_pc[1:0];

  // Request depends only on queue state and reset, never on redirect or out_ready.
  assign imem_req     = reset && !fifo_full;
  assign imem_addr    = pc_q;
  assign pc_next      = pc_q + PC_STEP;
  assign fetch_accept = imem_req && imem_ready && !redirect;
  assign pop          = !fifo_empty && out_ready && !redirect;

  assign push_entry.instruction = imem_data;
  assign push_entry.pc_plus4    = pc_next;

  assign out_valid       = !fifo_empty;
  assign out_instruction = head.instruction;
  assign out_pc_plus4    = head.pc_plus4;

  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
    end else if (fetch_accept) begin
      pc_d = pc_next;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q <= {RESET_PC[ADDR_W-1:2], 2'b00};
    end else begin
      pc_q <= pc_d;
    end
  end

  fetch_fifo #(
    .entry_t (entry_t),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (fetch_accept),
    .pop        (pop),
    .flush      (redirect),
    .push_entry (push_entry),
    .head       (head),
    .count      (occupancy),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

endmodule
